palindrome_frame_deser: RTL and testbench
=========================================

Name: palindrome_frame_deser

Overview:
- Serial-to-parallel front end for the parallel bit-palindrome checker.
- Collects a framed serial bitstream (valid/ready/last) MSB-first into one WIDTH-bit word and presents it on a valid/ready output with length and error tags.
- Its output feeds the combinational palindrome checker directly; out_err tells the consumer to ignore that check result.

Parameters:
- WIDTH, 16, bits per well-formed frame; must be ≥ 2. Even and odd values are both legal.
- LEN_W, $clog2(WIDTH+1), width of the received-length field.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a serial bit is offered.
- in_bit, input, 1, serial data bit.
- in_last, input, 1, marks the final bit of a frame.
- in_ready, output, 1, block accepts the offered bit this cycle.
- out_valid, output, 1, assembled word is held on the out_* outputs.
- out_ready, input, 1, downstream consumes the word.
- out_data, output, WIDTH, assembled word. First bit received lands at out_data[WIDTH-1].
- out_len, output, LEN_W, bits stored in out_data, saturating at WIDTH.
- out_err, output, 1, frame was short (len<WIDTH) or overlong (>WIDTH bits).

Behaviour:
- Reset (async assert, synchronous release): state=COLLECT, shift register=0, bit count=0, out_valid=0, out_data=0, out_len=0, out_err=0. in_ready is 0 while rst_n=0.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready), in every state. Input therefore stalls only when a finished word is held and not being taken.
- Shifting (COLLECT): each accepted bit does sreg <= {sreg[WIDTH-2:0], in_bit} and cnt <= cnt+1.
- States: COLLECT and DISCARD.
- COLLECT, accepted beat with in_last=1 and cnt+1==WIDTH: load the output register next cycle with out_data = shifted sreg, out_len = WIDTH, out_err = 0. Clear cnt and sreg; stay in COLLECT.
- COLLECT, accepted beat with in_last=1 and cnt+1<WIDTH (short frame): out_data = shifted sreg, right-justified, upper bits 0; out_len = cnt+1; out_err = 1. Clear cnt and sreg.
- COLLECT, accepted beat with in_last=0 and cnt+1==WIDTH (overlong start): go to DISCARD and keep the WIDTH captured bits. No output yet.
- DISCARD: accepted beats are dropped. On the beat with in_last=1, load the output with the captured bits, out_len = WIDTH, out_err = 1, and return to COLLECT.
- Single-bit frame (in_last on the first bit): short-frame path with out_len = 1, out_err = 1.
- Latency: out_valid rises the cycle after the last beat is accepted. Throughput is one bit per cycle with no bubble between frames.
- Output register: out_valid is set on load and cleared on out_valid && out_ready unless reloaded in the same cycle.
- Back-to-back frames: a simultaneous out_ready handshake and new final beat reloads the register, and out_valid stays 1.
- out_* hold stable while out_valid && !out_ready.
- Inputs are don't-care when in_valid=0, and do not change state.
- Mid-operation reset: a partial frame and any held word are discarded, with no output. The first frame after reset starts at cnt=0.

Decomposition:
- Shared package pal_pkg:
  - typedef enum {COLLECT, DISCARD} pal_deser_state_e
  - function clog2-based LEN_W helper
  - typedef struct {data, len, err} for the output word, parameterised through WIDTH in the package constant PAL_WIDTH_DEFAULT = 16
- One natural sub-module: pal_out_reg, the valid/ready output holding register (load, hold, consume/reload). Reused by the downstream result stage.

Test Plan (WIDTH=8):
- Reset: drive rst_n=0 mid-cycle. out_valid=0, out_data=0, out_len=0, out_err=0, in_ready=0 asynchronously.
- Nominal frame: bits 1,0,1,1,0,0,0,1 with in_last on the 8th bit, out_ready=1. One cycle later out_valid=1, out_data=8'hB1, out_len=8, out_err=0.
- Short frame: bits 1,1,0 with last. out_data=8'h06, out_len=3, out_err=1. Single-bit frame "1" gives out_data=8'h01, out_len=1, out_err=1.
- Overlong frame: 11 bits, first 8 = 8'h3C, then 1,0,1 with last on the 11th. Exactly one output: out_data=8'h3C, out_len=8, out_err=1; next frame decodes cleanly.
- Backpressure: out_ready=0 with a word held and the next frame streaming. in_ready=0 and out_data stable for 5 cycles. Release out_ready: both words are delivered in order, no bit lost.
- Back-to-back: two 8-bit frames 8'hA5 then 8'h5A, continuous in_valid, out_ready=1. out_valid stays high on consecutive handshakes, each delivering the correct word; reset asserted mid-frame discards the partial frame, with no out_valid after release.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared types and helpers for the bit-palindrome datapath.
//   pal_deser_state_e : serial deserializer states
//   pal_len_w()       : width of a length field that can hold 0..width
//   pal_word_t        : {data, len, err} word at the default width
package pal_pkg;

    localparam int PAL_WIDTH_DEFAULT = 16;

    function automatic int pal_len_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int PAL_LEN_W_DEFAULT = pal_len_w(PAL_WIDTH_DEFAULT);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } pal_deser_state_e;

    typedef struct packed {
        logic [PAL_WIDTH_DEFAULT-1:0] data;
        logic [PAL_LEN_W_DEFAULT-1:0] len;
        logic                         err;
    } pal_word_t;

endpackage

// File: rtl/pal_out_reg.sv
// Valid/ready output holding register.
// A load always wins: it captures the new payload and keeps valid high, even
// when the held word is being consumed in the same cycle. Otherwise a
// handshake clears valid, and the payload is held untouched while waiting.
//   clk, rst_n   : clock, async active-low reset
//   load         : capture load_payload this cycle
//   load_payload : word to capture
//   ready        : downstream consumes the held word
//   valid        : a word is held
//   payload      : held word
module pal_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_payload,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] payload
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            payload <= load_payload;
        end else if (valid && ready) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/palindrome_frame_deser.sv
// Serial-to-parallel front end for the bit-palindrome checker.
// Collects a valid/ready/last framed bitstream MSB-first into a WIDTH-bit
// word and presents it with its received length and an error tag.
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_bit/in_last: serial beat, in_last marks the frame end
//   in_ready               : beat accepted this cycle when in_valid is high
//   out_valid/out_ready    : output handshake
//   out_data               : first received bit at out_data[WIDTH-1] for full
//                            frames; short frames are right-justified
//   out_len                : bits stored, saturating at WIDTH
//   out_err                : frame was short or overlong
//
// state   | meaning
// COLLECT | shifting bits of the current frame into sreg
// DISCARD | WIDTH bits captured without last; dropping beats until last
module palindrome_frame_deser
    import pal_pkg::*;
#(
    parameter int WIDTH = PAL_WIDTH_DEFAULT,
    parameter int LEN_W = pal_len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
    localparam int PAY_W = WIDTH + LEN_W + 1;

    pal_deser_state_e state, state_next;
    logic [WIDTH-1:0] sreg, sreg_next, shifted;
    logic [LEN_W-1:0] cnt, cnt_next, cnt_inc;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             load_err;
    logic [PAY_W-1:0] payload;

    // Gate with rst_n so the block refuses beats while held in reset.
    assign in_ready = rst_n && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + LEN_W'(1);
    // sreg is cleared between frames, so short frames come out right-justified.
    assign shifted  = {sreg[WIDTH-2:0], in_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (accept && !in_last && cnt_inc == FULL_LEN) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (accept && in_last) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        sreg_next = sreg;
        cnt_next  = cnt;
        load      = 1'b0;
        load_data = sreg;
        load_len  = FULL_LEN;
        load_err  = 1'b1;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (in_last) begin
                        load      = 1'b1;
                        load_data = shifted;
                        load_len  = cnt_inc;
                        load_err  = (cnt_inc != FULL_LEN);
                        sreg_next = '0;
                        cnt_next  = '0;
                    end else begin
                        sreg_next = shifted;
                        // Count is irrelevant in DISCARD; park it at zero.
                        cnt_next  = (cnt_inc == FULL_LEN) ? '0 : cnt_inc;
                    end
                end
            end
            DISCARD: begin
                if (accept && in_last) begin
                    load      = 1'b1;
                    sreg_next = '0;
                    cnt_next  = '0;
                end
            end
            default: begin
                sreg_next = '0;
                cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            sreg <= sreg_next;
            cnt  <= cnt_next;
        end
    end

    pal_out_reg #(
        .W (PAY_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_payload ({load_data, load_len, load_err}),
        .ready        (out_ready),
        .valid        (out_valid),
        .payload      (payload)
    );

    assign {out_data, out_len, out_err} = payload;

endmodule

// File: tb/tb_palindrome_frame_deser.sv
module tb_palindrome_frame_deser;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_bit, in_last, in_ready;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LEN_W-1:0] out_len;
    logic             out_err;

    palindrome_frame_deser #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [LEN_W-1:0] l;
        logic             e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l, input logic e);
        exp_t x;
        x.d = d; x.l = l; x.e = e;
        sb.push_back(x);
        n_push++;
    endtask

    // Monitor: consumes a word on every handshake, away from the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word actual=%0h required=none", out_data);
                end else begin
                    x = sb.pop_front();
                    n_pop++;
                    check("out_data", 32'(out_data), 32'(x.d));
                    check("out_len",  32'(out_len),  32'(x.l));
                    check("out_err",  32'(out_err),  32'(x.e));
                end
            end
        end
    end

    // Sends n bits MSB-first; called at posedge+1, returns at posedge+1.
    task automatic send_bits(input logic [15:0] bits, input int n, input logic last);
        logic acc;
        int   waited;
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = last && (i == 0);
            acc      = 1'b0;
            waited   = 0;
            while (!acc && waited < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL in_ready_timeout actual=0 required=1");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_len",   32'(out_len),   32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Held word cleared asynchronously by a mid-cycle reset.
        out_ready = 1'b0;
        send_bits(16'h00FF, 8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data",  32'(out_data),  32'd0);
        check("async_out_len",   32'(out_len),   32'd0);
        check("async_out_err",   32'(out_err),   32'd0);
        check("async_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Nominal, short, single-bit frames.
        expect_word(8'hB1, 4'd8, 1'b0);
        send_bits(16'h00B1, 8, 1'b1);
        expect_word(8'h06, 4'd3, 1'b1);
        send_bits(16'h0006, 3, 1'b1);
        expect_word(8'h01, 4'd1, 1'b1);
        send_bits(16'h0001, 1, 1'b1);
        idle(2);

        // Overlong frame then a clean one.
        expect_word(8'h3C, 4'd8, 1'b1);
        send_bits(16'h01E5, 11, 1'b1);
        expect_word(8'h96, 4'd8, 1'b0);
        send_bits(16'h0096, 8, 1'b1);
        idle(2);

        // Backpressure: held word stalls the next frame.
        out_ready = 1'b0;
        expect_word(8'hC3, 4'd8, 1'b0);
        send_bits(16'h00C3, 8, 1'b1);
        expect_word(8'h69, 4'd8, 1'b0);
        fork
            send_bits(16'h0069, 8, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready",  32'(in_ready),  32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_out_data",  32'(out_data),  32'hC3);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(2);

        // Single-bit frames back to back: reload on every handshake.
        expect_word(8'h01, 4'd1, 1'b1);
        expect_word(8'h00, 4'd1, 1'b1);
        expect_word(8'h01, 4'd1, 1'b1);
        send_bits(16'h0001, 1, 1'b1);
        send_bits(16'h0000, 1, 1'b1);
        check("b2b_valid_held", 32'(out_valid), 32'd1);
        send_bits(16'h0001, 1, 1'b1);
        check("b2b_valid_held2", 32'(out_valid), 32'd1);
        idle(2);

        // Two full frames with continuous in_valid.
        expect_word(8'hA5, 4'd8, 1'b0);
        send_bits(16'h00A5, 8, 1'b1);
        expect_word(8'h5A, 4'd8, 1'b0);
        send_bits(16'h005A, 8, 1'b1);
        idle(2);

        // Reset during a partial frame: nothing comes out.
        send_bits(16'h000F, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("no_out_after_reset", 32'(saw), 32'd0);
        @(posedge clk); #1;
        expect_word(8'h81, 4'd8, 1'b0);
        send_bits(16'h0081, 8, 1'b1);
        idle(3);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("word_count", 32'(n_pop), 32'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
